// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing a 2*WIDTH-bit HI/LO result
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one registered WIDTH x WIDTH product in PREP.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a_in;
  logic [WIDTH-1:0] r_b_in;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_dz;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div_zero;

  logic               w_is_div;
  logic               w_is_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_mul_acc;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_div    = r_op[1];
  assign w_is_signed = r_op[0];
  assign w_abs_a     = (w_is_signed && r_a_in[WIDTH-1]) ? -r_a_in : r_a_in;
  assign w_abs_b     = (w_is_signed && r_b_in[WIDTH-1]) ? -r_b_in : r_b_in;

  // Shift-add step: {r_acc, r_q} is the partial product, multiplier bits leave r_q LSB first.
  assign w_sum     = r_acc + {1'b0, r_m};
  assign w_mul_acc = r_q[0] ? w_sum : r_acc;

  // Restoring step: r_q holds the remaining dividend bits and collects quotient bits from the right.
  assign w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_m};
  assign w_ge    = ~w_diff[WIDTH+1];

  assign w_prod   = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_s = r_neg_lo ? -w_prod : w_prod;
  assign w_quo    = r_neg_lo ? -r_q : r_q;
  assign w_rem    = r_neg_hi ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = (2*WIDTH)'(w_abs_a) * (2*WIDTH)'(w_abs_b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = S_PREP;
      S_PREP: begin
        w_state_next = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
        if (!w_is_div) w_state_next = S_FIX;
`endif
      end
      S_CALC: if (r_cnt == CNT_ONE) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_a_in      <= '0;
      r_b_in      <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_neg_lo    <= 1'b0;
      r_neg_hi    <= 1'b0;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      // out_valid trails entry into DONE by one edge and drops on the handshake edge.
      r_out_valid <= (r_state == S_DONE) && !(r_out_valid && out_ready);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op   <= op;
            r_a_in <= a;
            r_b_in <= b;
          end
        end
        S_PREP: begin
          r_q      <= w_abs_a;
          r_m      <= w_abs_b;
          r_acc    <= '0;
          r_cnt    <= CNT_INIT;
          r_neg_lo <= w_is_signed && (r_a_in[WIDTH-1] ^ r_b_in[WIDTH-1]);
          r_neg_hi <= w_is_signed && r_a_in[WIDTH-1];
          r_dz     <= w_is_div && (r_b_in == '0);
`ifdef MULDIV_FAST_MUL_EN
          if (!w_is_div) {r_acc, r_q} <= {1'b0, w_fast_prod};
`endif
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (w_is_div) begin
            r_acc <= w_ge ? w_diff[WIDTH:0] : w_shift;
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {1'b0, w_mul_acc[WIDTH:1]};
            r_q   <= {w_mul_acc[0], r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!w_is_div) begin
            r_hi       <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo       <= w_prod_s[WIDTH-1:0];
            r_div_zero <= 1'b0;
          end else if (r_dz) begin
            r_hi       <= r_a_in;
            r_lo       <= '1;
            r_div_zero <= 1'b1;
          end else begin
            r_hi       <= w_rem;
            r_lo       <= w_quo;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
// Build with and without MULDIV_FAST_MUL_EN; expected multiply latency follows the macro.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] e_hi;
  logic [W-1:0] e_lo;
  logic         e_dz;
  int           e_lat;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa    = longint'($signed(m_a));
    sb    = longint'($signed(m_b));
    e_dz  = 1'b0;
    e_lat = W + 3;
    p     = '0;
    case (m_op)
      2'b00: p = {32'd0, m_a} * {32'd0, m_b};
      2'b01: p = 64'(sa * sb);
      2'b10: begin
        if (m_b == '0) begin
          p = {m_a, 32'hFFFF_FFFF};
          e_dz = 1'b1;
        end else begin
          p = {m_a % m_b, m_a / m_b};
        end
      end
      default: begin
        if (m_b == '0) begin
          p = {m_a, 32'hFFFF_FFFF};
          e_dz = 1'b1;
        end else if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          p = {32'd0, 32'h8000_0000};
        end else begin
          p = {W'(sa % sb), W'(sa / sb)};
        end
      end
    endcase
    e_hi = p[63:32];
    e_lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
    if (!m_op[1]) e_lat = 3;
`endif
  endtask

  task automatic issue(input logic [1:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_issue", 64'(in_ready), 64'd1);
    model(t_op, t_a, t_b);
    op       = t_op;
    a        = t_a;
    b        = t_b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 2'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic collect(input int hold);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("hi", 64'(hi), 64'(e_hi));
    check("lo", 64'(lo), 64'(e_lo));
    check("div_zero", 64'(div_zero), 64'(e_dz));
    check("ready_in_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_hi", 64'(hi), 64'(e_hi));
      check("hold_lo", 64'(lo), 64'(e_lo));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_after_release", 64'(out_valid), 64'd0);
    check("ready_after_release", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]   d_op [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11};
  logic [W-1:0] d_a  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
  logic [W-1:0] d_b  [6] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      collect(0);
      release_result();
    end

    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    collect(10);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 2'b10;
    a         = 32'd100;
    b         = 32'd7;
    model(2'b10, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_idle_ready", 64'(in_ready), 64'd1);
    check("b2b_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_accepted", 64'(in_ready), 64'd0);
    collect(0);
    release_result();

    issue(2'b10, $urandom, $urandom);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;
    issue(2'b00, 32'd6, 32'd7);
    collect(0);
    release_result();

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), pick(), pick());
      collect($urandom_range(0, 3));
      release_result();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
